// File: rtl/select_pkg.sv
// Shared types and constants for the select_int32 block.
package select_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int NIBBLES   = WIDTH_DEF / 4;
    localparam int CNT_W     = 6;
    localparam int K_W       = 5;
    localparam int IDX_W     = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;
endpackage

// File: rtl/popcount_nibble.sv
// Combinational population count of a 4-bit nibble.
module popcount_nibble (
    input  logic [3:0] nib,
    output logic [2:0] cnt
);
    assign cnt = 3'(nib[0]) + 3'(nib[1]) + 3'(nib[2]) + 3'(nib[3]);
endmodule

// File: rtl/select_int32.sv
// Select (position of the K-th set bit) over a 32-bit word, one nibble per SCAN cycle.
// Optional macro SELECT_EARLY_EXIT_EN: finish on the first hit instead of constant 8-cycle latency.
module select_int32
    import select_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [K_W-1:0]   K,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic             found,
    output logic             out_valid,
    input  logic             out_ready
);
    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [K_W-1:0]   k_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             hit_reg;
    logic [4:0]       y_reg;
    logic             found_reg;

    logic [3:0]       nib [NIBBLES];
    logic [3:0]       cur_nib;
    logic [2:0]       nib_pop;
    logic [CNT_W-1:0] cnt_sum;
    logic             nib_hit;
    logic             last_nib;
    logic             accept;
    logic [1:0]       rank;
    logic [1:0]       offset;
    logic [1:0]       seen;
    logic             taken;

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign nib[gi] = a_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_nib = nib[idx_reg];

    popcount_nibble u_popcount_nibble (
        .nib (cur_nib),
        .cnt (nib_pop)
    );

    // Running count tops out at 32, so CNT_W bits never wrap.
    assign cnt_sum  = cnt_reg + CNT_W'(nib_pop);
    assign nib_hit  = !hit_reg && (cnt_sum > CNT_W'(k_reg));
    assign last_nib = (idx_reg == IDX_W'(NIBBLES - 1));
    assign accept   = in_valid && (state_reg == IDLE);
    // On a hit K - count is 0..3, so modulo-4 arithmetic gives the exact rank.
    assign rank     = k_reg[1:0] - cnt_reg[1:0];

    always_comb begin
        offset = 2'd0;
        seen   = 2'd0;
        taken  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cur_nib[i]) begin
                if (!taken && (seen == rank)) begin
                    offset = 2'(i);
                    taken  = 1'b1;
                end
                seen = seen + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
`ifdef SELECT_EARLY_EXIT_EN
                if (nib_hit || last_nib) begin
                    state_next = DONE;
                end
`else
                if (last_nib) begin
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            k_reg     <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            hit_reg   <= 1'b0;
            y_reg     <= '0;
            found_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= A;
            k_reg     <= K;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            hit_reg   <= 1'b0;
            y_reg     <= '0;
            found_reg <= 1'b0;
        end else if (state_reg == SCAN) begin
            if (nib_hit) begin
                y_reg     <= {idx_reg, offset};
                found_reg <= 1'b1;
                hit_reg   <= 1'b1;
            end else if (!hit_reg) begin
                cnt_reg <= cnt_sum;
            end
            if (!last_nib) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign found     = found_reg;
    assign Y         = {{(WIDTH-5){1'b0}}, y_reg};
endmodule

// File: tb/tb_select_int32.sv
// Self-checking bench for select_int32: vector table plus scoreboard, backpressure and reset-abort sequences.
module tb_select_int32;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [4:0]  K;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Y;
    logic        found;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] y;
        logic        found;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  k;
        logic [31:0] y;
        logic        found;
        int          hold;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    select_int32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .K         (K),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .found     (found),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Bit-serial reference: walk bits upward counting ones.
    task automatic ref_select(input logic [31:0] a, input logic [4:0] k,
                              output logic [31:0] y, output logic f);
        int c;
        c = 0;
        y = 32'd0;
        f = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                if (!f && c == int'(k)) begin
                    y = 32'(i);
                    f = 1'b1;
                end
                c++;
            end
        end
    endtask

    function automatic int ref_lat(input logic [31:0] y, input logic f);
`ifdef SELECT_EARLY_EXIT_EN
        return f ? int'(y) / 4 + 1 : 8;
`else
        return (y == 32'hFFFF_FFFF && f) ? 0 : 8;
`endif
    endfunction

    task automatic run_req(input logic [31:0] a, input logic [4:0] k, input int hold,
                           input logic [31:0] tbl_y, input logic tbl_f, input logic use_tbl);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          w;
        logic [31:0] y0;
        logic        f0;
        ref_select(a, k, e.y, e.found);
        if (use_tbl) begin
            e.y     = tbl_y;
            e.found = tbl_f;
        end
        e.lat = ref_lat(e.y, e.found);
        sb.push_back(e);

        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_idle", in_ready, 1);
        A = a;
        K = k;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom;
        K = 5'($urandom_range(31, 0));
        chk("in_ready_busy", in_ready, 0);

        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 20);
        chk("out_valid", out_valid, 1);

        got = sb.pop_front();
        chk("Y", Y, got.y);
        chk("found", found, got.found);
        chk("latency", lat, got.lat);

        y0 = Y;
        f0 = found;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_Y", Y, y0);
            chk("hold_found", found, f0);
            chk("hold_in_ready", in_ready, 0);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        $display("req a=%08h k=%0d -> y=%0d found=%0d lat=%0d", a, k, y0, f0, lat);
    endtask

    initial begin
        logic aborted_valid;
        rst = 1'b1;
        A = '0;
        K = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{32'h0000_0001,  5'd0,  32'd0, 1'b1, 0};
        vecs[1] = '{32'hFFFF_FFFF, 5'd31, 32'd31, 1'b1, 0};
        vecs[2] = '{32'h8000_0100,  5'd0,  32'd8, 1'b1, 0};
        vecs[3] = '{32'h8000_0100,  5'd1, 32'd31, 1'b1, 0};
        vecs[4] = '{32'h0000_00F0,  5'd4,  32'd0, 1'b0, 0};
        vecs[5] = '{32'h0000_0000,  5'd0,  32'd0, 1'b0, 0};
        vecs[6] = '{32'h0000_00F0,  5'd3,  32'd7, 1'b1, 5};
        vecs[7] = '{32'h0F00_0000,  5'd2, 32'd26, 1'b1, 0};

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_Y", Y, 0);
        chk("rst_found", found, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].a, vecs[i].k, vecs[i].hold, vecs[i].y, vecs[i].found, 1'b1);
        end

        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if (i % 4 == 0) ra = ra & $urandom;
            run_req(ra, 5'($urandom_range(31, 0)), i % 3, 32'd0, 1'b0, 1'b0);
        end

        // Reset in the middle of a scan must abort without a result.
        @(negedge clk);
        A = 32'hFFFF_FFFF;
        K = 5'd31;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_Y", Y, 0);
        chk("abort_found", found, 0);
        @(negedge clk);
        rst = 1'b0;
        aborted_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            aborted_valid = aborted_valid | out_valid;
        end
        chk("abort_no_result", aborted_valid, 0);
        run_req(32'h0000_0010, 5'd0, 0, 32'd4, 1'b1, 1'b1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
